// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite encodings and the slave-side bus bundle
// used by the SRAM slave.
package ahb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;
endpackage

interface ahb_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite,
    output hsize, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite,
    input  hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: registered address phase, word array,
// fixed wait states and a two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst,
  ahb_sram_slave_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LANES = DATA_W / 8;
  localparam logic [2:0] WLAST =
    (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_XFER, S_ERR1, S_ERR2
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        wcnt, wcnt_nx;
  logic [IDX_W-1:0]  a_idx;
  logic [1:0]        a_lane;
  logic [2:0]        a_size;
  logic              a_write;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              open, accept, bad;
  logic [LANES-1:0]  be;
  logic              unused_bits;

  assign unused_bits = ^bus.haddr[ADDR_W-1:IDX_W+2];

  // only states that end a data phase may take a new address
  assign open = (state == S_IDLE) || (state == S_XFER) ||
                (state == S_ERR2);
  assign accept = open && bus.hsel && bus.hready &&
                  (bus.htrans == NONSEQ || bus.htrans == SEQ);

  always_comb begin
    bad = 1'b1;
    unique case (bus.hsize)
      3'd0:    bad = 1'b0;
      3'd1:    bad = bus.haddr[0];
      3'd2:    bad = |bus.haddr[1:0];
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      S_WAIT: begin
        if (wcnt == WLAST) state_nx = S_XFER;
        else wcnt_nx = wcnt + 3'd1;
      end
      S_ERR1: state_nx = S_ERR2;
      default: begin
        wcnt_nx = 3'd0;
        if (!accept)              state_nx = S_IDLE;
        else if (bad)             state_nx = S_ERR1;
        else if (WAIT_STATES > 0) state_nx = S_WAIT;
        else                      state_nx = S_XFER;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      wcnt    <= 3'd0;
      a_idx   <= '0;
      a_lane  <= 2'd0;
      a_size  <= 3'd0;
      a_write <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (accept) begin
        a_idx   <= bus.haddr[IDX_W+1:2];
        a_lane  <= bus.haddr[1:0];
        a_size  <= bus.hsize;
        a_write <= bus.hwrite;
      end
    end
  end

  always_comb begin
    be = '0;
    unique case (a_size)
      3'd0: be[a_lane] = 1'b1;
      3'd1: begin
        be[{a_lane[1], 1'b0}] = 1'b1;
        be[{a_lane[1], 1'b1}] = 1'b1;
      end
      default: be = '1;
    endcase
  end

  // array has no reset; contents survive rst
  always_ff @(posedge clk) begin
    if (!rst && state == S_XFER && a_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[a_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hreadyout = !(state == S_WAIT || state == S_ERR1);
  assign bus.hresp = (state == S_ERR1 || state == S_ERR2) ?
                     ERROR : OKAY;
  assign bus.hrdata = (state == S_XFER && !a_write) ?
                      mem[a_idx] : '0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: instances with 1, 0 and 3 wait states
// share one stimulus bus; a scoreboard checks every data phase.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          resp;
  } vec_t;

  typedef struct {
    int          waits;
    bit          resp;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        hsel, hwrite, hblk;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  int          dut;

  logic        ro [3];
  logic        rp [3];
  logic [31:0] rd [3];
  logic        cur_ready, cur_resp;
  logic [31:0] cur_rdata;

  assign cur_ready = ro[dut];
  assign cur_resp  = rp[dut];
  assign cur_rdata = rd[dut];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    assign bus.hsel   = hsel && (dut == g);
    assign bus.haddr  = haddr;
    assign bus.htrans = htrans;
    assign bus.hwrite = hwrite;
    assign bus.hsize  = hsize;
    assign bus.hwdata = hwdata;
    assign bus.hready = hblk ? 1'b0 : cur_ready;
    assign ro[g] = bus.hreadyout;
    assign rp[g] = bus.hresp;
    assign rd[g] = bus.hrdata;
    ahb_sram_slave #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(512),
      .WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t req_q [$];
  exp_t sb [$];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut %0d, t=%0t): got %h expected %h",
               name, dut, $time, act, exp);
    end
  endtask

  function automatic int ws_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  function automatic vec_t mk(bit s, logic [1:0] t, bit w,
                              logic [2:0] z, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rv,
                              bit rs);
    vec_t v;
    v.sel = s; v.trans = t; v.write = w; v.size = z;
    v.addr = a; v.wdata = wd; v.rdata = rv; v.resp = rs;
    return v;
  endfunction

  // pipelined master: address of next op overlaps data of current
  task automatic run();
    vec_t ap, dp;
    exp_t e;
    bit   ap_v, dp_v, stall_resp;
    int   waits, guard;
    dp_v = 0; waits = 0; guard = 0; stall_resp = 0;
    ap_v = (req_q.size() > 0);
    if (ap_v) ap = req_q.pop_front();
    while (ap_v || dp_v) begin
      hsel   = ap_v && ap.sel;
      htrans = ap_v ? ap.trans : 2'b00;
      hwrite = ap_v && ap.write;
      hsize  = ap_v ? ap.size : 3'd0;
      haddr  = ap_v ? ap.addr : 32'd0;
      hwdata = dp_v ? dp.wdata : 32'd0;
      @(negedge clk);
      if (dp_v) begin
        if (!cur_ready) begin
          waits++;
          stall_resp = cur_resp;
        end else begin
          e = sb.pop_front();
          check("resp", cur_resp, e.resp);
          check("waits", waits, e.waits);
          check("rdata", cur_rdata, e.rdata);
          if (e.waits > 0) check("stall_resp", stall_resp, e.resp);
          dp_v = 0;
        end
      end
      if (cur_ready && ap_v) begin
        e.resp  = ap.resp;
        e.rdata = ap.rdata;
        e.waits = ap.resp ? 1 :
                  ((ap.sel && ap.trans[1]) ? ws_of(dut) : 0);
        sb.push_back(e);
        dp = ap; dp_v = 1; waits = 0;
        ap_v = (req_q.size() > 0);
        if (ap_v) ap = req_q.pop_front();
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL timeout: got no completion expected one");
        req_q.delete(); sb.delete();
        break;
      end
    end
    hsel = 0; htrans = 2'b00; hwrite = 0; hwdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    dut = 0; hsel = 0; htrans = 2'b00; hwrite = 0; hsize = 3'd0;
    haddr = 32'd0; hwdata = 32'd0; hblk = 0;
    #12;
    for (int d = 0; d < 3; d++) begin
      dut = d; #1;
      check("rst_ready", cur_ready, 1);
      check("rst_resp", cur_resp, 0);
      check("rst_rdata", cur_rdata, 0);
    end
    dut = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    tbl.push_back(mk(1, NONSEQ, 1, 2, 'h010, 'hDEADBEEF, 0, 0));
    tbl.push_back(mk(1, NONSEQ, 0, 2, 'h010, 0, 'hDEADBEEF, 0));
    tbl.push_back(mk(1, NONSEQ, 1, 2, 'h020, 0, 0, 0));
    tbl.push_back(mk(1, NONSEQ, 1, 0, 'h021, 'h0000AA00, 0, 0));
    tbl.push_back(mk(1, NONSEQ, 1, 1, 'h022, 'hBBBB0000, 0, 0));
    tbl.push_back(mk(1, NONSEQ, 0, 2, 'h020, 0, 'hBBBBAA00, 0));
    tbl.push_back(mk(1, NONSEQ, 0, 2, 'h006, 0, 0, 1));
    tbl.push_back(mk(1, NONSEQ, 1, 2, 'h004, 'h44444444, 0, 0));
    tbl.push_back(mk(1, NONSEQ, 0, 2, 'h004, 0, 'h44444444, 0));
    tbl.push_back(mk(1, NONSEQ, 1, 1, 'h013, 'hFFFFFFFF, 0, 1));
    tbl.push_back(mk(1, NONSEQ, 1, 3, 'h010, 'hFFFFFFFF, 0, 1));
    tbl.push_back(mk(1, NONSEQ, 0, 2, 'h010, 0, 'hDEADBEEF, 0));
    tbl.push_back(mk(1, IDLE, 1, 2, 'h010, 0, 0, 0));
    tbl.push_back(mk(1, BUSY, 1, 2, 'h010, 0, 0, 0));
    tbl.push_back(mk(0, NONSEQ, 1, 2, 'h010, 'h12345678, 0, 0));
    tbl.push_back(mk(1, NONSEQ, 0, 2, 'h010, 0, 'hDEADBEEF, 0));
    for (int i = 0; i < tbl.size(); i++) req_q.push_back(tbl[i]);
    run();

    // selected NONSEQ while another slave holds hready low
    hsel = 1; htrans = NONSEQ; hwrite = 1; hsize = 3'd2;
    haddr = 32'h010; hblk = 1;
    @(posedge clk); #1;
    hsel = 0; htrans = 2'b00; hblk = 0; hwdata = 32'h12345678;
    check("blk_ready", cur_ready, 1);
    check("blk_resp", cur_resp, 0);
    @(posedge clk); #1;
    hwdata = 32'd0;
    check("blk_ready2", cur_ready, 1);
    req_q.push_back(mk(1, NONSEQ, 0, 2, 'h010, 0, 'hDEADBEEF, 0));
    run();

    // reset during the wait state of a write
    req_q.push_back(mk(1, NONSEQ, 1, 2, 'h030, 'h11111111, 0, 0));
    run();
    hsel = 1; htrans = NONSEQ; hwrite = 1; hsize = 3'd2;
    haddr = 32'h030;
    @(posedge clk); #1;
    hsel = 0; htrans = 2'b00; hwrite = 0; hwdata = 32'h22222222;
    check("wait_ready", cur_ready, 0);
    #2 rst = 1;
    #1;
    check("arst_ready", cur_ready, 1);
    check("arst_resp", cur_resp, 0);
    check("arst_rdata", cur_rdata, 0);
    @(posedge clk); #1;
    rst = 0; hwdata = 32'd0;
    @(posedge clk); #1;
    req_q.push_back(mk(1, NONSEQ, 0, 2, 'h030, 0, 'h11111111, 0));
    req_q.push_back(mk(1, NONSEQ, 1, 2, 'h030, 'h33333333, 0, 0));
    req_q.push_back(mk(1, NONSEQ, 0, 2, 'h030, 0, 'h33333333, 0));
    run();

    // 4-beat bursts on the zero- and three-wait instances
    for (int d = 1; d < 3; d++) begin
      dut = d;
      for (int i = 0; i < 4; i++)
        req_q.push_back(mk(1, (i == 0) ? NONSEQ : SEQ, 1, 2,
                           32'h100 + 32'(4 * i),
                           32'hC0DE0000 + 32'(d * 256 + i), 0, 0));
      for (int i = 0; i < 4; i++)
        req_q.push_back(mk(1, (i == 0) ? NONSEQ : SEQ, 0, 2,
                           32'h100 + 32'(4 * i), 0,
                           32'hC0DE0000 + 32'(d * 256 + i), 0));
      run();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
